// File: rtl/wpt_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the power-transfer fabric.
// AW and W each sit in a one-deep buffer; a commit needs both buffers full and no pending B response.
module wpt_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic [3:0][DW-1:0] regs_q, regs_d;
  logic               aw_full_q, aw_full_d;
  logic [1:0]         aw_addr_q, aw_addr_d;
  logic               w_full_q, w_full_d;
  logic [DW-1:0]      w_data_q, w_data_d;
  logic [SW-1:0]      w_strb_q, w_strb_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  always_comb begin
    regs_d    = regs_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;

    if (S_AXI_AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR[3:2];
    end
    if (S_AXI_WVALID && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    // Ready is low whenever a buffer is full, so capture and commit never collide.
    if (aw_full_q && w_full_q && !bvalid_q) begin
      for (int i = 0; i < SW; i++)
        if (w_strb_q[i]) regs_d[aw_addr_q][8*i +: 8] = w_data_q[8*i +: 8];
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // regs_q is the pre-edge value, so a same-edge commit is not visible here.
    if (S_AXI_ARVALID && arready_q) begin
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      rvalid_d = 1'b1;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      regs_q    <= '0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign slv_reg0      = regs_q[0];
  assign slv_reg1      = regs_q[1];
  assign slv_reg2      = regs_q[2];
  assign slv_reg3      = regs_q[3];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_wpt_axil_regs.sv
// Directed bench for wpt_axil_regs: inputs driven and outputs sampled on the falling edge.
module tb_wpt_axil_regs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, r0, r1, r2, r3;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  wpt_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_reg0(r0), .slv_reg1(r1), .slv_reg2(r2), .slv_reg3(r3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sreg(input logic [3:0] a);
    case (a[3:2])
      2'd0: return r0;
      2'd1: return r1;
      2'd2: return r2;
      default: return r3;
    endcase
  endfunction

  // AW and W together, then a B handshake with BREADY high.
  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got_b = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs)  begin w_done  = 1; wvalid  = 0; end
    end
    awvalid = 0; wvalid = 0;
    chk("wr_accept_timeout", {31'd0, aw_done && w_done}, 32'd1);
    bready = 1;
    for (int i = 0; i < 20 && !got_b; i++) begin
      if (bvalid) got_b = 1;
      else @(negedge clk);
    end
    chk("bvalid_timeout", {31'd0, got_b}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bit hs = 0;
    @(negedge clk);
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20 && !hs; i++) begin
      if (arready) hs = 1;
      @(negedge clk);
    end
    arvalid = 0;
    chk({tag, "_ar_timeout"}, {31'd0, hs}, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
    chk(tag, rdata, exp);
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk({tag, "_rvalid_clr"}, {31'd0, rvalid}, 32'd0);
  endtask

  logic [3:0]  wa [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
  logic [31:0] wd [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
  bit seen_b;

  initial begin
    rst_n = 0; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 0; arvalid = 0; rready = 0;

    // Reset
    repeat (25) @(negedge clk);
    chk("rst_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_regs", r0 | r1 | r2 | r3, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);

    // Basic write / readback
    for (int i = 0; i < 4; i++) begin
      axi_wr(wa[i], wd[i], 4'hF);
      chk($sformatf("slv_reg%0d", i), sreg(wa[i]), wd[i]);
      axi_rd(wa[i], wd[i], $sformatf("rd%0d", i));
    end

    // W three cycles ahead of AW, BREADY held low
    @(negedge clk);
    wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); wvalid = 0;
    chk("w_buf_wready", {31'd0, wready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("w_only_nocommit", r1, 32'hABCD0001);
    chk("w_only_nob", {31'd0, bvalid}, 32'd0);
    awaddr = 4'h4; awvalid = 1;
    @(negedge clk); awvalid = 0;
    @(negedge clk);
    chk("late_aw_b", {31'd0, bvalid}, 32'd1);
    chk("late_aw_reg1", r1, 32'h00000055);
    awaddr = 4'hC; wdata = 32'h00000077; awvalid = 1; wvalid = 1;
    @(negedge clk); awvalid = 0; wvalid = 0;
    chk("buf2_readies", {30'd0, awready, wready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bvalid_held", {31'd0, bvalid}, 32'd1);
    chk("buf2_nocommit", r3, 32'hBEEF0011);
    bready = 1;
    @(negedge clk); bready = 0;
    chk("b_cleared", {31'd0, bvalid}, 32'd0);
    chk("buf2_still_old", r3, 32'hBEEF0011);
    @(negedge clk);
    chk("buf2_b", {31'd0, bvalid}, 32'd1);
    chk("buf2_commit", r3, 32'h00000077);
    bready = 1;
    @(negedge clk); bready = 0;

    // Byte strobes
    axi_wr(4'h8, 32'hAABBCCDD, 4'hF);
    axi_wr(4'h8, 32'h11223344, 4'b0101);
    axi_rd(4'h8, 32'hAA22CC44, "wstrb");

    // Same-edge commit and read of reg 2
    axi_wr(4'h8, 32'hDEAD0011, 4'hF);
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 4'h8; arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("same_edge_rvalid", {31'd0, rvalid}, 32'd1);
    chk("same_edge_old", rdata, 32'hDEAD0011);
    chk("same_edge_reg2", r2, 32'h12345678);
    chk("same_edge_b", {31'd0, bvalid}, 32'd1);
    rready = 1; bready = 1;
    @(negedge clk); rready = 0; bready = 0;
    axi_rd(4'h8, 32'h12345678, "after_same_edge");

    // Reset with BVALID pending and AW buffered
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'hCAFEF00D; awvalid = 1; wvalid = 1;
    @(negedge clk); awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("pre_rst_b", {31'd0, bvalid}, 32'd1);
    awaddr = 4'h4; awvalid = 1;
    @(negedge clk); awvalid = 0;
    chk("pre_rst_awbuf", {31'd0, awready}, 32'd0);
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_b", {31'd0, bvalid}, 32'd0);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);
    for (int i = 0; i < 4; i++) axi_rd(wa[i], 32'd0, $sformatf("post_rst_rd%0d", i));
    // A lone W must not pair with a stale AW.
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); wvalid = 0;
    seen_b = 0;
    repeat (4) begin @(negedge clk); if (bvalid) seen_b = 1; end
    chk("stale_aw_no_b", {31'd0, seen_b}, 32'd0);
    chk("stale_aw_regs", r0 | r1 | r2 | r3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wpt_axil_regs.md
# wpt_axil_regs

AXI4-Lite slave register file that the Zynq-side AXI master drives to configure the inductive power-transfer fabric. It holds four 32-bit control registers at word offsets 0x0, 0x4, 0x8 and 0xC, with full write and readback. Every register is exported as a port to downstream fabric logic. It is the stage directly fed by the AXI4-Lite master and answers each transaction with an OKAY response.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; bits [3:2] select the register and bits [1:0] are ignored.
- S_AXI_ACLK  in  1  single clock; every flop is on its rising edge.
- S_AXI_ARESETN  in  1  reset: synchronous, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; constant 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; constant 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- slv_reg0..slv_reg3  out  32 each  live register contents, to fabric.

## Operation
- **Reset** (ARESETN low at an edge):
  - all registers, slv_reg*, RDATA, BVALID, RVALID, AWREADY, WREADY and ARREADY go to 0;
  - the AW and W hold buffers are cleared and any in-flight transaction is discarded without a response.
- **Ready signals after reset:**
  - AWREADY = 1 when the AW buffer is empty, 0 while it holds an address.
  - WREADY = 1 when the W buffer is empty, 0 while it holds data.
  - ARREADY = 1 when RVALID = 0.
- **Write path:**
  - AW and W are accepted independently, in either order or together. Each is held in a one-deep buffer.
  - When both buffers are full and BVALID = 0, the commit happens at the next edge:
    - byte i of slv_reg[AWADDR[3:2]] takes WDATA[8i+7:8i] where WSTRB[i] = 1; other bytes keep their value;
    - both buffers clear;
    - BVALID goes to 1.
  - BVALID holds until an edge with BREADY = 1, then goes to 0.
  - While BVALID = 1, new AW/W may be buffered but not committed.
- **Read path:**
  - On the AR handshake edge, RDATA latches the register selected by ARADDR[3:2] using pre-edge contents, and RVALID goes to 1.
  - RDATA and RVALID hold until an edge with RREADY = 1, after which RVALID goes to 0.
- **Write commit and AR handshake on the same edge, same register:** RDATA returns the old value; slv_reg shows the new value after that edge.
- **Read and write paths are fully independent**; neither stalls the other.
- **Address range:** any address maps to one of the four registers, so there is no error response.

## Timing
- **Write, AW and W presented together at edge E:** captured at E, register updated and BVALID = 1 at E+1, BVALID cleared at the first edge ≥ E+2 with BREADY = 1.
- **Write throughput:** at most one write per 2 cycles with BREADY held high.
- **Read latency:** RVALID = 1 at the AR handshake edge (registered one cycle after ARVALID is sampled).
- **Read throughput:** one read per 2 cycles with RREADY held high, since ARREADY is low while RVALID = 1.
- **slv_reg\* outputs:** change only at a commit edge; no combinational path from the AXI inputs.
- **Output stability:** BRESP, RRESP and RDATA are stable while the corresponding VALID is high.

## Test plan
- Reset held for 25 cycles, then released → all outputs 0 during reset; AWREADY = WREADY = ARREADY = 1 one cycle after release.
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x0, 0x4, 0x8, 0xC, each followed by a read of the same address → BRESP = RRESP = 0, readback matches the written value, slv_reg0..3 match.
- W presented 3 cycles before AW, with BREADY low for 4 cycles → no commit until AW is accepted; BVALID held; the second write is buffered but not committed until the B handshake.
- WSTRB = 4'b0101 with data 0x11223344 over a register holding 0xAABBCCDD → register reads 0xAA22CC44.
- Read of 0x8 on the same edge as a commit of 0x12345678 to 0x8 (old value 0xDEAD0011) → RDATA = 0xDEAD0011; next read returns 0x12345678.
- ARESETN pulled low while BVALID = 1 and while the AW buffer is held → no B response after reset; registers read 0.
